uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 or 8E1 framing, registered serial output.
// One byte in flight; requests while busy are dropped.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TX_START_BIT  = 3'd1,
        TX_DATA_BITS  = 3'd2,
        TX_PARITY_BIT = 3'd3,
        TX_STOP_BIT   = 3'd4,
        CLEANUP       = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    idx_inc;
    logic [7:0]    data_q, data_d;
    logic          serial_q, serial_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign idx_inc = idx_q + 3'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
        end
    end

    // serial_d is the line value for the state being entered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (i_tx_dv) begin
                    data_d   = i_tx_byte;
                    serial_d = 1'b0;
                    state_d  = TX_START_BIT;
                end
            end
            TX_START_BIT: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = data_q[0];
                    state_d  = TX_DATA_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_DATA_BITS: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            serial_d = ^data_q;
                            state_d  = TX_PARITY_BIT;
                        end else begin
                            serial_d = 1'b1;
                            state_d  = TX_STOP_BIT;
                        end
                    end else begin
                        idx_d    = idx_inc;
                        serial_d = data_q[idx_inc];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_PARITY_BIT: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    state_d  = TX_STOP_BIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_STOP_BIT: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    state_d  = CLEANUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CLEANUP: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    assign o_tx_serial = serial_q;
    assign o_tx_ready  = (state_q == IDLE);
    assign o_tx_done   = (state_q == CLEANUP);
    assign o_tx_active = (state_q == TX_START_BIT)  ||
                         (state_q == TX_DATA_BITS)  ||
                         (state_q == TX_PARITY_BIT) ||
                         (state_q == TX_STOP_BIT);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 8N1 and 8E1 instances at 4 clocks per bit,
// elapsed-time line model plus a frame scoreboard fed at acceptance.
module tb_uart_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit fin [2];

    task automatic check(input string name, input int k,
                         input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", name, k, got, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int P = k;
        localparam int FRAME = (10 + P) * C;

        logic       rst_n = 1'b0;
        logic       dv = 1'b0;
        logic [7:0] tx_byte = 8'h00;
        logic       ready, serial, active, done;

        uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(P == 1)) dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_tx_dv    (dv),
            .i_tx_byte  (tx_byte),
            .o_tx_ready (ready),
            .o_tx_serial(serial),
            .o_tx_active(active),
            .o_tx_done  (done)
        );

        // t = cycles since acceptance (0 = idle), frame + cleanup + idle
        int         t = 0;
        int         acc_cnt = 0;
        logic [7:0] cur = 8'h00;
        logic [7:0] exp_q [$];

        int   cyc = 0;
        int   starts = 0;
        int   start_cyc = 0;
        int   done_cyc = -100;
        int   b2b_idx = -1;
        bit   in_frame = 1'b0;
        logic samples [$];

        function automatic logic exp_bit(input int i, input logic [7:0] b);
            if (i == 0) return 1'b0;
            if (i <= 8) return b[i-1];
            if (i == 9 && P == 1) return ^b;
            return 1'b1;
        endfunction

        initial forever begin
            @(posedge clk);
            if (!rst_n) begin
                t = 0;
                exp_q.delete();
            end else if (t == 0 && dv) begin
                cur = tx_byte;
                t = 1;
                acc_cnt++;
                exp_q.push_back(tx_byte);
            end else if (t == FRAME + 1) begin
                t = 0;
            end else if (t > 0) begin
                t++;
            end
        end

        initial forever begin
            logic es, ea, ed, er;
            logic [7:0] gb;
            int bitbad;
            logic [7:0] e;
            @(negedge clk);
            if (!rst_n || t == 0) begin
                {es, ea, ed, er} = 4'b1001;
            end else if (t <= FRAME) begin
                {es, ea, ed, er} = {exp_bit((t - 1) / C, cur), 3'b100};
            end else begin
                {es, ea, ed, er} = 4'b1010;
            end
            check("line", k, {28'b0, serial, active, done, ready},
                  {28'b0, es, ea, ed, er});

            if (!rst_n) begin
                samples.delete();
                in_frame = 1'b0;
            end else begin
                if (active) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        starts++;
                        start_cyc = cyc;
                        if (starts == b2b_idx)
                            check("b2b_gap", k, cyc - done_cyc, 2);
                    end
                    samples.push_back(serial);
                end
                if (done) begin
                    in_frame = 1'b0;
                    done_cyc = cyc;
                    check("done_lat", k, cyc - start_cyc, FRAME);
                    check("line_len", k, samples.size(), FRAME);
                    check("sb_pending", k, exp_q.size(), 1);
                    if (exp_q.size() > 0 && samples.size() == FRAME) begin
                        e = exp_q.pop_front();
                        gb = 8'h00;
                        for (int j = 0; j < 8; j++)
                            gb[j] = samples[C/2 + (j + 1) * C];
                        check("data", k, gb, e);
                        check("start_bit", k, samples[C/2], 0);
                        for (int i = 9; i < FRAME / C; i++)
                            check("tail_bit", k, samples[C/2 + i * C],
                                  exp_bit(i, e));
                        bitbad = 0;
                        for (int s = 0; s < FRAME; s++)
                            if (samples[s] !== samples[(s / C) * C + C/2])
                                bitbad++;
                        check("bit_hold", k, bitbad, 0);
                    end else if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                    end
                    samples.delete();
                end
            end
            cyc++;
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [7:0] b, input bit keep);
            int n0;
            int g;
            n0 = acc_cnt;
            g = 0;
            dv = 1'b1;
            tx_byte = b;
            while (acc_cnt == n0 && g < 4 * FRAME) begin
                step();
                g++;
            end
            check("accept_to", k, acc_cnt - n0, 1);
            if (!keep) dv = 1'b0;
            tx_byte = 8'($urandom);
        endtask

        task automatic wait_idle();
            int g;
            g = 0;
            while ((t != 0 || in_frame) && g < 4 * FRAME) begin
                step();
                g++;
            end
            check("idle_to", k, t, 0);
        endtask

        initial begin
            logic [7:0] dir [4];
            bit keep;
            dir = '{8'hA5, 8'h07, 8'h03, 8'h3C};
            dv = 1'b1;
            tx_byte = 8'h11;
            repeat (3) step();
            check("rst_ready", k, ready, 1);
            check("rst_serial", k, serial, 1);
            check("rst_active", k, active, 0);
            check("rst_done", k, done, 0);
            check("rst_noacc", k, acc_cnt, 0);
            rst_n = 1'b1;
            send(8'h11, 1'b0);
            wait_idle();

            for (int i = 0; i < 4; i++) begin
                send(dir[i], 1'b0);
                wait_idle();
            end

            send(8'h55, 1'b1);
            b2b_idx = acc_cnt + 1;
            send(8'hAA, 1'b0);
            wait_idle();

            send(8'h96, 1'b0);
            repeat (2 * C) step();
            dv = 1'b1;
            tx_byte = 8'h69;
            check("busy_ready", k, ready, 0);
            step();
            dv = 1'b0;
            check("busy_ready2", k, ready, 0);
            wait_idle();

            send(8'hC3, 1'b0);
            repeat (4 * C + 1) step();
            check("pre_rst_bit3", k, serial, 0);
            rst_n = 1'b0;
            #1;
            check("mid_rst_serial", k, serial, 1);
            check("mid_rst_active", k, active, 0);
            check("mid_rst_done", k, done, 0);
            repeat (3) step();
            rst_n = 1'b1;
            step();
            send(8'($urandom), 1'b0);
            wait_idle();

            for (int i = 0; i < 24; i++) begin
                keep = ($urandom_range(0, 3) == 0) && (i != 23);
                send(8'($urandom), keep);
                if (!keep) repeat ($urandom_range(0, 3)) step();
            end
            dv = 1'b0;
            wait_idle();
            check("sb_empty", k, exp_q.size(), 0);
            fin[k] = 1'b1;
        end
    end

    initial begin
        int g;
        g = 0;
        while (!(fin[0] && fin[1]) && g < 20000) begin
            @(posedge clk);
            g++;
        end
        check("finish_to", 0, {31'b0, fin[0] & fin[1]}, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
